// File: rtl/cordic_tone_gen_pkg.sv
// Shared constants, FSM encoding and lookup helpers for the CORDIC tone generator.
// The arctangent table is scaled so that 2^16 phase units equal one full turn.
package cordic_pkg;

   localparam int DEF_WIDTH   = 12;
   localparam int DEF_PHASE_W = 16;
   localparam int DEF_ITER    = 12;
   localparam int DEF_DIV_W   = 16;

   // CORDIC gain K = 0.607253, held in parts per million for integer rounding
   localparam longint K_PPM = 64'd607253;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ITER, ST_DONE} state_t;

   // round(atan(2^-i)/pi * 2^15); entries past i=14 are zero
   function automatic int atan_lut(input int i);
      case (i)
         0:       return 8192;
         1:       return 4836;
         2:       return 2555;
         3:       return 1297;
         4:       return 651;
         5:       return 326;
         6:       return 163;
         7:       return 81;
         8:       return 41;
         9:       return 20;
         10:      return 10;
         11:      return 5;
         12:      return 3;
         13:      return 1;
         14:      return 1;
         default: return 0;
      endcase
   endfunction

   // Pre-scaled start vector: round(K * (2^(width-1) - 1))
   function automatic int cordic_x0(input int width);
      longint full_scale;
      full_scale = (longint'(1) << (width - 1)) - 1;
      return int'((K_PPM * full_scale + 64'd500000) / 64'd1000000);
   endfunction

endpackage

// File: rtl/cordic_tone_gen_if.sv
// Control inputs and sample outputs of the tone generator, bundled for the PWM-side consumer.
interface cordic_tone_gen_if import cordic_pkg::*; #(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int PHASE_W = DEF_PHASE_W,
   parameter int DIV_W   = DEF_DIV_W
);
   logic               en;
   logic [PHASE_W-1:0] freq_word;
   logic [DIV_W-1:0]   tick_div;
   logic [WIDTH-1:0]   sample;
   logic               sample_valid;
   logic               busy;
   logic               overrun;

   modport master (
      output en, freq_word, tick_div,
      input  sample, sample_valid, busy, overrun
   );

   modport slave (
      input  en, freq_word, tick_div,
      output sample, sample_valid, busy, overrun
   );
endinterface

// File: rtl/cordic_tone_gen_step.sv
// One combinational CORDIC micro-rotation in rotation mode (drive z toward zero).
module cordic_iter_step import cordic_pkg::*; #(
   parameter int XW      = DEF_WIDTH + 2,
   parameter int PHASE_W = DEF_PHASE_W,
   parameter int IW      = $clog2(DEF_PHASE_W)
) (
   input  logic signed [XW-1:0]      x,
   input  logic signed [XW-1:0]      y,
   input  logic signed [PHASE_W-1:0] z,
   input  logic [IW-1:0]             i,
   output logic signed [XW-1:0]      x_next,
   output logic signed [XW-1:0]      y_next,
   output logic signed [PHASE_W-1:0] z_next
);
   logic signed [PHASE_W-1:0] atan_rom [2**IW];
   logic signed [XW-1:0]      x_shift;
   logic signed [XW-1:0]      y_shift;
   logic signed [PHASE_W-1:0] angle;

   generate
      for (genvar gi = 0; gi < 2**IW; gi++) begin : g_atan
         assign atan_rom[gi] = PHASE_W'(atan_lut(gi));
      end
   endgenerate

   always_comb begin
      x_shift = x >>> i;
      y_shift = y >>> i;
      angle   = atan_rom[i];
      if (!z[PHASE_W-1]) begin
         x_next = x - y_shift;
         y_next = y + x_shift;
         z_next = z - angle;
      end else begin
         x_next = x + y_shift;
         y_next = y - x_shift;
         z_next = z + angle;
      end
   end
endmodule

// File: rtl/cordic_tone_gen.sv
// Sample-rate sine source: tick divider, phase accumulator and an iterative CORDIC
// whose saturated result is held on sample until the next accepted tick completes.
module cordic_tone_gen import cordic_pkg::*; #(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int PHASE_W = DEF_PHASE_W,
   parameter int ITER    = DEF_ITER,
   parameter int DIV_W   = DEF_DIV_W
) (
   input logic               clk,
   input logic               rst,
   cordic_tone_gen_if.slave  bus
);
   localparam int XW = WIDTH + 2;
   localparam int IW = $clog2(PHASE_W);
   localparam logic signed [XW-1:0] X0     = XW'(cordic_x0(WIDTH));
   localparam logic signed [XW:0]   SAT_HI = (XW+1)'((1 << (WIDTH - 1)) - 1);
   localparam logic signed [XW:0]   SAT_LO = -SAT_HI;

   state_t                    state_reg;
   logic [DIV_W-1:0]          count_reg;
   logic [PHASE_W-1:0]        phase_reg;
   logic signed [XW-1:0]      x_reg, y_reg;
   logic signed [PHASE_W-1:0] z_reg;
   logic [IW-1:0]             idx_reg;
   logic                      neg_reg;
   logic [WIDTH-1:0]          sample_reg;
   logic                      valid_reg, busy_reg, overrun_reg;

   logic                      tick;
   logic signed [XW-1:0]      x_next, y_next;
   logic signed [PHASE_W-1:0] z_next;
   logic signed [XW:0]        y_ext, y_fold;
   logic [WIDTH-1:0]          sample_next;

   assign tick = bus.en && (count_reg == bus.tick_div);

   cordic_iter_step #(.XW(XW), .PHASE_W(PHASE_W), .IW(IW)) u_step (
      .x      (x_reg),
      .y      (y_reg),
      .z      (z_reg),
      .i      (idx_reg),
      .x_next (x_next),
      .y_next (y_next),
      .z_next (z_next)
   );

   // Undo the quadrant fold and clamp symmetrically so the most negative code never appears
   always_comb begin
      y_ext  = {y_next[XW-1], y_next};
      y_fold = neg_reg ? -y_ext : y_ext;
      if (y_fold > SAT_HI)
         sample_next = WIDTH'(SAT_HI);
      else if (y_fold < SAT_LO)
         sample_next = WIDTH'(SAT_LO);
      else
         sample_next = WIDTH'(y_fold);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         count_reg   <= '0;
         phase_reg   <= '0;
         x_reg       <= '0;
         y_reg       <= '0;
         z_reg       <= '0;
         idx_reg     <= '0;
         neg_reg     <= 1'b0;
         sample_reg  <= '0;
         valid_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         if (bus.en)
            count_reg <= tick ? '0 : count_reg + DIV_W'(1);
         if (tick && state_reg != ST_IDLE)
            overrun_reg <= 1'b1;
         case (state_reg)
            ST_IDLE: begin
               if (tick) begin
                  z_reg     <= phase_reg;
                  phase_reg <= phase_reg + bus.freq_word;
                  busy_reg  <= 1'b1;
                  state_reg <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               // Angles in [pi/2, 3pi/2) are mirrored by pi and the result negated
               if (z_reg[PHASE_W-1] != z_reg[PHASE_W-2]) begin
                  z_reg   <= {~z_reg[PHASE_W-1], z_reg[PHASE_W-2:0]};
                  neg_reg <= 1'b1;
               end else begin
                  neg_reg <= 1'b0;
               end
               x_reg     <= X0;
               y_reg     <= '0;
               idx_reg   <= '0;
               state_reg <= ST_ITER;
            end
            ST_ITER: begin
               x_reg   <= x_next;
               y_reg   <= y_next;
               z_reg   <= z_next;
               idx_reg <= idx_reg + IW'(1);
               if (idx_reg == IW'(ITER - 1)) begin
                  sample_reg <= sample_next;
                  valid_reg  <= 1'b1;
                  state_reg  <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.sample       = sample_reg;
   assign bus.sample_valid = valid_reg;
   assign bus.busy         = busy_reg;
   assign bus.overrun      = overrun_reg;
endmodule

// File: tb/tb_cordic_tone_gen.sv
// Self-checking bench: cycle model of divider/phase/busy feeds a scoreboard of expected sine samples.
module tb_cordic_tone_gen;
   import cordic_pkg::*;

   localparam int LAT    = DEF_ITER + 2;
   localparam int SB_TOL = 8;
   localparam int Q_TOL  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cordic_tone_gen_if #(.WIDTH(12), .PHASE_W(16), .DIV_W(16)) bus();

   cordic_tone_gen dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [15:0] phase;
      int          due;
   } exp_t;

   typedef struct {
      logic [15:0] freq;
      logic [15:0] div;
      int          nsamp;
      logic        exp_ovr;
   } vec_t;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int valid_cnt = 0;
   exp_t sb_q[$];

   logic [15:0] m_phase = '0;
   logic [15:0] m_count = '0;
   int          m_busy = 0;
   logic        m_overrun = 1'b0;
   logic        m_tick;

   assign m_tick = bus.en && (m_count == bus.tick_div);

   task automatic check(input string name, input bit ok, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic real sine_ref(input logic [15:0] p);
      return 2047.0 * $sin(2.0 * 3.14159265358979 * real'(p) / 65536.0);
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Reference model of divider, phase accumulator and busy window
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         m_phase   <= '0;
         m_count   <= '0;
         m_busy    <= 0;
         m_overrun <= 1'b0;
         sb_q.delete();
      end else begin
         if (bus.en)
            m_count <= m_tick ? 16'd0 : m_count + 16'd1;
         if (m_tick && m_busy == 0) begin
            sb_q.push_back('{m_phase, cyc + LAT});
            m_phase <= m_phase + bus.freq_word;
            m_busy  <= LAT;
         end else begin
            if (m_tick)
               m_overrun <= 1'b1;
            if (m_busy > 0)
               m_busy <= m_busy - 1;
         end
      end
   end

   // Scoreboard / monitor, sampled away from the active edge
   always @(negedge clk) begin
      exp_t e;
      int   s;
      int   ref_s;
      check("busy", bus.busy === (m_busy != 0), int'(bus.busy), int'(m_busy != 0));
      check("overrun", bus.overrun === m_overrun, int'(bus.overrun), int'(m_overrun));
      if (bus.sample_valid === 1'b1) begin
         valid_cnt++;
         if (sb_q.size() == 0) begin
            check("unexpected_valid", 1'b0, 1, 0);
         end else begin
            e = sb_q.pop_front();
            s = int'($signed(bus.sample));
            ref_s = int'(sine_ref(e.phase));
            check("latency", cyc == e.due, cyc - (e.due - LAT), LAT);
            check("sb_sample", iabs(s - ref_s) <= SB_TOL, s, ref_s);
         end
      end else if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
         e = sb_q.pop_front();
         check("missed_valid", 1'b0, 0, 1);
      end
   end

   task automatic do_reset();
      rst    = 1'b1;
      bus.en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_valid(output int s, output int at);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.sample_valid !== 1'b1 && n < 500);
      if (bus.sample_valid !== 1'b1) begin
         check("valid_timeout", 1'b0, n, 500);
         s = 0;
      end else begin
         s = int'($signed(bus.sample));
      end
      at = cyc;
   endtask

   task automatic wait_busy(input logic level);
      int n;
      n = 0;
      while (bus.busy !== level && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy !== level)
         check("busy_timeout", 1'b0, int'(bus.busy), int'(level));
   endtask

   initial begin
      vec_t vt[5];
      int   qexp[4];
      int   s, at, prev_at, v0, len, vat, n, target;

      vt[0] = '{16'h1000, 16'd14, 6, 1'b0};
      vt[1] = '{16'h2345, 16'd13, 6, 1'b1};
      vt[2] = '{16'hFFFF, 16'd16, 5, 1'b0};
      vt[3] = '{16'h0123, 16'd40, 4, 1'b0};
      vt[4] = '{16'h7777, 16'd5,  4, 1'b1};
      qexp  = '{0, 2047, 0, -2047};

      bus.en        = 1'b0;
      bus.freq_word = '0;
      bus.tick_div  = '0;
      rst           = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_sample", bus.sample === 12'd0, int'($signed(bus.sample)), 0);
      check("rst_valid", bus.sample_valid === 1'b0, int'(bus.sample_valid), 0);
      check("rst_busy", bus.busy === 1'b0, int'(bus.busy), 0);
      check("rst_overrun", bus.overrun === 1'b0, int'(bus.overrun), 0);
      rst = 1'b0;
      v0 = valid_cnt;
      repeat (100) @(negedge clk);
      check("idle_no_valid", valid_cnt == v0, valid_cnt - v0, 0);

      // Zero frequency: constant phase 0, one pulse every 32 clocks
      bus.freq_word = 16'h0000;
      bus.tick_div  = 16'd31;
      bus.en        = 1'b1;
      prev_at = 0;
      for (int k = 0; k < 4; k++) begin
         wait_valid(s, at);
         $display("zero_freq: sample %0d at cycle %0d", s, at);
         check("zero_sample", iabs(s) <= Q_TOL, s, 0);
         if (k > 0)
            check("zero_period", at - prev_at == 32, at - prev_at, 32);
         prev_at = at;
      end

      // Quarter-turn steps
      do_reset();
      bus.freq_word = 16'h4000;
      bus.tick_div  = 16'd20;
      bus.en        = 1'b1;
      for (int k = 0; k < 8; k++) begin
         wait_valid(s, at);
         $display("quarter: step %0d sample %0d", k, s);
         check("quarter_sample", iabs(s - qexp[k % 4]) <= Q_TOL, s, qexp[k % 4]);
      end

      // Busy window and latency of a single computation
      do_reset();
      bus.freq_word = 16'h1234;
      bus.tick_div  = 16'd20;
      bus.en        = 1'b1;
      wait_busy(1'b1);
      len = 0;
      vat = -1;
      while (bus.busy === 1'b1 && len < 100) begin
         if (bus.sample_valid === 1'b1)
            vat = len;
         len++;
         @(negedge clk);
      end
      $display("latency: busy %0d cycles, valid in busy cycle %0d", len, vat);
      check("busy_len", len == LAT, len, LAT);
      check("valid_pos", vat == LAT - 1, vat, LAT - 1);

      // Table-driven runs, each from reset
      for (int t = 0; t < 5; t++) begin
         do_reset();
         bus.freq_word = vt[t].freq;
         bus.tick_div  = vt[t].div;
         bus.en        = 1'b1;
         target = valid_cnt + vt[t].nsamp;
         n = 0;
         while (valid_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
         end
         $display("vector %0d: freq %h div %0d samples %0d overrun %0d", t, vt[t].freq,
                  vt[t].div, vt[t].nsamp - (target - valid_cnt), bus.overrun);
         check("vec_samples", valid_cnt >= target, valid_cnt - (target - vt[t].nsamp), vt[t].nsamp);
         check("vec_overrun", bus.overrun === vt[t].exp_ovr, int'(bus.overrun), int'(vt[t].exp_ovr));
      end

      // Overrun is sticky until reset
      bus.en = 1'b0;
      repeat (50) @(negedge clk);
      check("ovr_sticky", bus.overrun === 1'b1, int'(bus.overrun), 1);
      do_reset();
      @(negedge clk);
      check("ovr_cleared", bus.overrun === 1'b0, int'(bus.overrun), 0);

      // Reset during iteration
      bus.freq_word = 16'h2000;
      bus.tick_div  = 16'd20;
      bus.en        = 1'b1;
      wait_valid(s, at);
      wait_busy(1'b0);
      wait_busy(1'b1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      $display("mid_reset: busy %0d sample %0d valid %0d", bus.busy, $signed(bus.sample), bus.sample_valid);
      check("midrst_busy", bus.busy === 1'b0, int'(bus.busy), 0);
      check("midrst_sample", bus.sample === 12'd0, int'($signed(bus.sample)), 0);
      check("midrst_valid", bus.sample_valid === 1'b0, int'(bus.sample_valid), 0);
      rst    = 1'b0;
      bus.en = 1'b0;
      v0 = valid_cnt;
      repeat (30) @(negedge clk);
      check("midrst_no_valid", valid_cnt == v0, valid_cnt - v0, 0);

      // Enable dropped mid-computation still yields one sample
      do_reset();
      bus.freq_word = 16'h1000;
      bus.tick_div  = 16'd20;
      bus.en        = 1'b1;
      wait_busy(1'b1);
      repeat (4) @(negedge clk);
      bus.en = 1'b0;
      v0 = valid_cnt;
      repeat (40) @(negedge clk);
      $display("en_drop: valids after drop %0d", valid_cnt - v0);
      check("endrop_one_valid", valid_cnt - v0 == 1, valid_cnt - v0, 1);
      check("sb_drained", sb_q.size() == 0, sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
